circ_smpl_queue: RTL and testbench

CIRC_SMPL_QUEUE -- requirements
Module: circ_smpl_queue

---
 rtl/circ_queue_pkg.sv | 18 +
 rtl/smpl_dpram.sv | 29 ++
 rtl/circ_smpl_queue.sv | 173 +++++++++++++++++
 tb/tb_circ_smpl_queue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circ_queue_pkg.sv
// Shared constants and types for the circular sample queue.
// Holds the default parameters, the two band depths and the readout state encoding.
package circ_queue_pkg;

  localparam int unsigned WIDTH_DEF       = 16;
  localparam int unsigned DEPTH_DEF       = 1021;
  localparam int unsigned CHANNELS_DEF    = 2;
  localparam int unsigned DECIMATE_DEF    = 2;

  localparam int unsigned DEPTH_LOW_BAND  = 1021;
  localparam int unsigned DEPTH_HIGH_BAND = 1531;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_ISSUE = 1'b1
  } rd_state_e;

endpackage

// File: rtl/smpl_dpram.sv
// Simple dual-port sample memory: one write port, one registered read port.
// Contents are not reset; the queue never reads a location before writing it.
module smpl_dpram
  import circ_queue_pkg::*;
#(
  parameter int DEPTH = int'(DEPTH_DEF),
  parameter int DW    = int'(WIDTH_DEF * CHANNELS_DEF),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/circ_smpl_queue.sv
// Decimating circular sample queue; every accepted write that leaves the queue
// full replays all DEPTH samples, oldest first, with a fixed two-cycle latency.
module circ_smpl_queue
  import circ_queue_pkg::*;
#(
  parameter int WIDTH    = int'(WIDTH_DEF),
  parameter int DEPTH    = int'(DEPTH_DEF),
  parameter int CHANNELS = int'(CHANNELS_DEF),
  parameter int DECIMATE = int'(DECIMATE_DEF)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      wrt_smpl,
  input  logic [CHANNELS*WIDTH-1:0] new_smpl,
  output logic [CHANNELS*WIDTH-1:0] smpl_out,
  output logic                      sequencing,
  output logic                      full,
  output logic                      ovr,
  output rd_state_e                 dbg_state_o
);

  localparam int PW  = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = CHANNELS * WIDTH;
  localparam int PHW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]  LAST_P  = PW'(DEPTH - 1);
  localparam logic [PHW-1:0] PH_LAST = PHW'(DECIMATE - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  logic           wrt_q, armed_q;
  logic [PHW-1:0] phase_q, phase_d;
  logic [PW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  new_ptr_q, new_ptr_d;
  logic [PW-1:0]  old_ptr_q, old_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  rd_left_q, rd_left_d;
  rd_state_e      rd_state_q, rd_state_d;
  logic           pipe_vld_q, pipe_vld_d;
  logic           seq_q, seq_d;
  logic [DW-1:0]  smpl_out_q, smpl_out_d;
  logic           ovr_q, ovr_d;

  logic          strobe, accept, busy, store, was_full, start_rd, rd_en;
  logic [DW-1:0] ram_rdata;

  // armed_q blocks a level that is already high when reset releases from
  // counting as a rising edge.
  always_comb begin
    strobe   = wrt_smpl & ~wrt_q & armed_q;
    accept   = strobe & (phase_q == '0);
    // Drop window runs from the accepting edge until sequencing falls, so the
    // snapshot being replayed can never be overwritten.
    busy     = (rd_state_q == RD_ISSUE) | pipe_vld_q | seq_q;
    store    = accept & ~busy & ~clr;
    was_full = (cnt_q == DEPTH_P);
    start_rd = store & (was_full | (cnt_q == LAST_P));

    phase_d   = phase_q;
    cnt_d     = cnt_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    ovr_d     = ovr_q | (accept & busy);

    if (strobe) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PHW'(1);
    if (store) begin
      new_ptr_d = ptr_inc(new_ptr_q);
      if (was_full) old_ptr_d = ptr_inc(old_ptr_q);
      else          cnt_d     = cnt_q + PW'(1);
    end

    if (clr) begin
      phase_d   = '0;
      cnt_d     = '0;
      new_ptr_d = '0;
      old_ptr_d = '0;
      ovr_d     = 1'b0;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_left_d  = rd_left_q;
    rd_en      = 1'b0;

    unique case (rd_state_q)
      RD_IDLE: begin
        if (start_rd) begin
          rd_state_d = RD_ISSUE;
          rd_ptr_d   = old_ptr_d;
          rd_left_d  = DEPTH_P;
        end
      end
      RD_ISSUE: begin
        rd_en     = 1'b1;
        rd_ptr_d  = ptr_inc(rd_ptr_q);
        rd_left_d = rd_left_q - PW'(1);
        if (rd_left_q == PW'(1)) rd_state_d = RD_IDLE;
      end
    endcase

    if (clr) begin
      rd_state_d = RD_IDLE;
      rd_ptr_d   = '0;
      rd_left_d  = '0;
    end
  end

  always_comb begin
    pipe_vld_d = rd_en & ~clr;
    seq_d      = pipe_vld_q & ~clr;
    smpl_out_d = (pipe_vld_q & ~clr) ? ram_rdata : smpl_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_q      <= 1'b0;
      armed_q    <= 1'b0;
      phase_q    <= '0;
      cnt_q      <= '0;
      new_ptr_q  <= '0;
      old_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      rd_left_q  <= '0;
      rd_state_q <= RD_IDLE;
      pipe_vld_q <= 1'b0;
      seq_q      <= 1'b0;
      smpl_out_q <= '0;
      ovr_q      <= 1'b0;
    end else begin
      wrt_q      <= wrt_smpl;
      armed_q    <= armed_q | ~wrt_smpl;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      new_ptr_q  <= new_ptr_d;
      old_ptr_q  <= old_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_left_q  <= rd_left_d;
      rd_state_q <= rd_state_d;
      pipe_vld_q <= pipe_vld_d;
      seq_q      <= seq_d;
      smpl_out_q <= smpl_out_d;
      ovr_q      <= ovr_d;
    end
  end

  smpl_dpram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (store),
    .waddr_i (new_ptr_q[AW-1:0]),
    .wdata_i (new_smpl),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign smpl_out    = smpl_out_q;
  assign sequencing  = seq_q;
  assign full        = (cnt_q == DEPTH_P);
  assign ovr         = ovr_q;
  assign dbg_state_o = rd_state_q;

endmodule

// File: tb/tb_circ_smpl_queue.sv
// Bench for circ_smpl_queue: two instances (DECIMATE 1 and 2, DEPTH 8) share
// stimulus; a queue-based reference model is compared every cycle.
module tb_circ_smpl_queue;
  import circ_queue_pkg::*;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        wrt_smpl = 1'b0;
  logic [31:0] new_smpl = '0;

  logic [31:0] a_out, b_out;
  logic        a_seq, b_seq, a_full, b_full, a_ovr, b_ovr;
  rd_state_e   a_st, b_st;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  circ_smpl_queue #(.WIDTH(16), .DEPTH(D), .CHANNELS(2), .DECIMATE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wrt_smpl(wrt_smpl), .new_smpl(new_smpl),
    .smpl_out(a_out), .sequencing(a_seq), .full(a_full), .ovr(a_ovr), .dbg_state_o(a_st)
  );

  circ_smpl_queue #(.WIDTH(16), .DEPTH(D), .CHANNELS(2), .DECIMATE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wrt_smpl(wrt_smpl), .new_smpl(new_smpl),
    .smpl_out(b_out), .sequencing(b_seq), .full(b_full), .ovr(b_ovr), .dbg_state_o(b_st)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0 = dut_a, 1 = dut_b) ----------------
  logic [31:0] mq [2][$];
  logic [31:0] snap [2][D];
  bit          prev_w [2];
  bit          armed [2];
  int          phase [2];
  bit          m_ovr [2];
  bit          rd_on [2];
  int          rd_s [2];
  logic        exp_seq [2];
  logic [31:0] exp_out [2];
  int          m_edge = 0;

  task automatic model_reset(input int m);
    mq[m].delete();
    prev_w[m]  = 1'b0;
    armed[m]   = 1'b0;
    phase[m]   = 0;
    m_ovr[m]   = 1'b0;
    rd_on[m]   = 1'b0;
    rd_s[m]    = 0;
    exp_seq[m] = 1'b0;
    exp_out[m] = '0;
  endtask

  // A readout accepted at edge s shows sample i after edge s+2+i; writes
  // accepted at edges s+1 .. s+D+2 are dropped.
  task automatic model_edge(input int m, input int dec, input int k);
    bit strobe, acc, busy;
    int rel;
    strobe = (wrt_smpl === 1'b1) && !prev_w[m] && armed[m];
    if (wrt_smpl !== 1'b1) armed[m] = 1'b1;
    prev_w[m] = (wrt_smpl === 1'b1);
    if (clr === 1'b1) begin
      mq[m].delete();
      phase[m]   = 0;
      m_ovr[m]   = 1'b0;
      rd_on[m]   = 1'b0;
      exp_seq[m] = 1'b0;
      return;
    end
    rel  = k - rd_s[m];
    busy = rd_on[m] && rel >= 1 && rel <= D + 2;
    exp_seq[m] = 1'b0;
    if (rd_on[m] && rel >= 2 && rel <= D + 1) begin
      exp_seq[m] = 1'b1;
      exp_out[m] = snap[m][rel-2];
    end
    if (rd_on[m] && rel >= D + 2) rd_on[m] = 1'b0;
    if (strobe) begin
      acc = (phase[m] == 0);
      phase[m] = (phase[m] + 1) % dec;
      if (acc) begin
        if (busy) m_ovr[m] = 1'b1;
        else begin
          mq[m].push_back(new_smpl);
          if (mq[m].size() > D) void'(mq[m].pop_front());
          if (mq[m].size() == D) begin
            rd_on[m] = 1'b1;
            rd_s[m]  = k;
            for (int i = 0; i < D; i++) snap[m][i] = mq[m][i];
          end
        end
      end
    end
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      m_edge++;
      model_edge(0, 1, m_edge);
      model_edge(1, 2, m_edge);
    end
  end

  always @(negedge clk) begin
    check_bit("m_a_seq",  a_seq,  exp_seq[0]);
    check    ("m_a_out",  a_out,  exp_out[0]);
    check_bit("m_a_full", a_full, mq[0].size() == D);
    check_bit("m_a_ovr",  a_ovr,  m_ovr[0]);
    check_bit("m_b_seq",  b_seq,  exp_seq[1]);
    check    ("m_b_out",  b_out,  exp_out[1]);
    check_bit("m_b_full", b_full, mq[1].size() == D);
    check_bit("m_b_ovr",  b_ovr,  m_ovr[1]);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk(input logic [15:0] lft);
    logic [15:0] rght;
    rght = lft + 16'h0100;
    return {rght, lft};
  endfunction

  // Raise for one edge, lower for one edge; returns at the negedge after the
  // edge following the accepting edge.
  task automatic strobe_write(input logic [31:0] data);
    new_smpl = data;
    wrt_smpl = 1'b1;
    @(negedge clk);
    wrt_smpl = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Called right after strobe_write of the filling sample: sequencing must be
  // seen at the next negedge (two edges after acceptance) for exactly D cycles.
  task automatic capture(input bit sel_b, input int start, input int step,
                         input bit inject, input string tag);
    int lat;
    logic [15:0] v;
    lat = 0;
    while (((sel_b ? b_seq : a_seq) !== 1'b1) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd1);
    for (int i = 0; i < D; i++) begin
      v = 16'(start + i * step);
      check_bit({tag, "_seq"}, sel_b ? b_seq : a_seq, 1'b1);
      check({tag, "_smpl"}, sel_b ? b_out : a_out, mk(v));
      if (inject && i == 3) begin
        new_smpl = mk(16'h00AA);
        wrt_smpl = 1'b1;
      end
      if (inject && i == 4) wrt_smpl = 1'b0;
      @(negedge clk);
    end
    check_bit({tag, "_seq_end"}, sel_b ? b_seq : a_seq, 1'b0);
  endtask

  typedef struct {
    int          grp;
    logic [15:0] lft;
    logic        exp_full;
  } wvec_t;

  wvec_t vecs [15];

  task automatic run_group(input int g, input int rd_start);
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].grp == g) begin
        strobe_write(mk(vecs[i].lft));
        check_bit($sformatf("grp%0d_full_%0d", g, i), a_full, vecs[i].exp_full);
        if (vecs[i].exp_full) capture(1'b0, rd_start, 1, 1'b0, $sformatf("grp%0d_rd", g));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = '{0, 16'(i + 1), (i == 7)};
    for (int i = 0; i < 7; i++) vecs[8 + i] = '{1, 16'(16'h51 + i), (i == 6)};

    // Reset state
    repeat (3) @(negedge clk);
    check_bit("rst_a_seq", a_seq, 1'b0);
    check_bit("rst_a_full", a_full, 1'b0);
    check_bit("rst_a_ovr", a_ovr, 1'b0);
    check("rst_a_out", a_out, 32'h0);
    check("rst_b_out", b_out, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with 1..8, readout 1..8
    run_group(0, 1);

    // One more write: stays full, readout wraps 2..9
    strobe_write(mk(16'd9));
    check_bit("w9_full", a_full, 1'b1);
    capture(1'b0, 2, 1, 1'b0, "rd9");

    // Strobe during readout: dropped, sticky ovr
    strobe_write(mk(16'd10));
    capture(1'b0, 3, 1, 1'b1, "rd10_ovr");
    check_bit("ovr_set", a_ovr, 1'b1);
    strobe_write(mk(16'd11));
    capture(1'b0, 4, 1, 1'b0, "rd11");
    check_bit("ovr_sticky", a_ovr, 1'b1);
    pulse_clr();
    check_bit("clr_ovr", a_ovr, 1'b0);
    check_bit("clr_full", a_full, 1'b0);
    check_bit("clr_seq", a_seq, 1'b0);

    // Decimate by 2: 1,3,..,15 stored and replayed
    for (int n = 1; n <= 15; n++) strobe_write(mk(16'(n)));
    check_bit("dec2_full", b_full, 1'b1);
    capture(1'b1, 1, 2, 1'b0, "dec2_rd");
    strobe_write(mk(16'd16));

    // Level held high for 5 cycles counts once
    pulse_clr();
    new_smpl = mk(16'h0050);
    wrt_smpl = 1'b1;
    repeat (5) @(negedge clk);
    wrt_smpl = 1'b0;
    @(negedge clk);
    check_bit("held_full", a_full, 1'b0);
    run_group(1, 16'h50);

    // Asynchronous reset in the middle of a readout
    strobe_write(mk(16'h0058));
    repeat (3) @(negedge clk);
    check_bit("pre_rst_seq", a_seq, 1'b1);
    #1;
    rst_n = 1'b0;
    wrt_smpl = 1'b1;
    #1;
    check_bit("async_rst_seq", a_seq, 1'b0);
    check("async_rst_out", a_out, 32'h0);
    check_bit("async_rst_full", a_full, 1'b0);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wrt_smpl = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 7; n++) strobe_write(mk(16'(16'h60 + n)));
    check_bit("post_rst_full", a_full, 1'b0);
    repeat (4) @(negedge clk);
    check_bit("post_rst_seq", a_seq, 1'b0);

    // Randomized traffic against the model
    pulse_clr();
    for (int c = 0; c < 600; c++) begin
      clr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0) wrt_smpl = ~wrt_smpl;
      new_smpl = $urandom;
      @(negedge clk);
    end
    clr = 1'b0;
    wrt_smpl = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
